pe_product_accumulator: RTL
===========================

Name: pe_product_accumulator

Overview:
Consumer end of the mult_ip product stream inside the PE. It accepts a stream of 12-bit products P, sums a window of LEN consecutive products (for example a 3x3 kernel, LEN=9), and presents each window sum on a valid/ready output port. An input-side in_ready provides backpressure to the operand feeder while an unread result is held.

Parameters:
P_W, 12, product width; matches mult_ip P output (8x4)
ACC_W, 20, accumulator and result width; must be >= P_W
LEN, 9, products per window; must be >= 1
CNT_W, 4, counter width; must satisfy 2^CNT_W > LEN

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; when 0, all state freezes
clear  input  1  synchronous abort of the current window
in_valid  input  1  P is valid this cycle
in_ready  output  1  block can accept P this cycle
P  input  P_W  product from mult_ip
acc_out  output  ACC_W  window sum, registered
out_valid  output  1  acc_out holds an unread result
out_ready  input  1  downstream accepts acc_out
overflow  output  1  current/held window exceeded ACC_W
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc=0, cnt=0, acc_out=0, out_valid=0, overflow=0.
- Priority per edge: rst_n, then clear, then en=0 (hold all registers), then normal operation.
- accept = en & in_valid & in_ready.
- in_ready = en & (state!=HOLD | out_ready).
- States:
  - IDLE: on accept, acc<=ext(P), cnt<=1, overflow<=0. Next state is ACCUM, or HOLD if LEN==1.
  - ACCUM: on accept, acc<=acc+ext(P), cnt<=cnt+1. When the accept is the LEN-th product, acc_out<=acc+ext(P), out_valid<=1, state<=HOLD. acc and cnt are reset to 0 in the same edge.
  - HOLD: acc_out and overflow are stable. On en & out_valid & out_ready, out_valid<=0 and state<=IDLE.
    - If accept occurs in the same cycle, P becomes product 1 of the next window. acc<=ext(P), cnt<=1, overflow<=0, state<=ACCUM (or HOLD again with a new result if LEN==1).
- Latency: out_valid rises on the edge that accepts the LEN-th product. Result is visible in the following cycle.
- Products with in_valid=0 or in_ready=0 are ignored. The upstream source must hold P.
- Arithmetic: ext() is a zero-extend to ACC_W. Sum wraps modulo 2^ACC_W.
  - overflow is set sticky on any carry out of bit ACC_W-1 within the window.
  - It is cleared at the first accept of the next window, and by clear or reset.
- clear: state<=IDLE, acc<=0, cnt<=0, out_valid<=0, overflow<=0. acc_out keeps its last value.
- en=0 mid-window: cnt, acc, state and out_valid all hold. in_ready=0. No product is lost or double-counted.

Optional Feature:
Macro ACC_SIGNED_EN.
- Defined: P is two's complement; ext() sign-extends. overflow flags signed overflow (operands' signs equal, result sign differs).
- Undefined: unsigned zero-extend and carry-out overflow, as above.
- Ports and timing are identical in both builds.

Test Plan:
- Defaults; 9 back-to-back accepts with P=1, out_ready=1 -> out_valid pulses 1 cycle after 9th accept; acc_out=9; overflow=0.
- P=4095 x9, ACC_W=14 -> acc_out=4087 (36855 mod 16384); overflow=1. Next window with P=1 x9 -> acc_out=9, overflow=0.
- Backpressure:
  - Window of P=2 x9 completes with out_ready=0 for 5 cycles -> in_ready=0, acc_out=18 held.
  - Then out_ready=1 with in_valid, P=3 -> result consumed and P=3 counted. Next window of eight more P=3 -> acc_out=27.
- Stall and clear:
  - en=0 for 4 cycles after 4th product of P=5 x9 -> no change while stalled; final acc_out=45.
  - Separately, clear after 5 products -> busy=0, out_valid=0. A fresh 9x P=1 window gives 9.
- Async reset: assert rst_n=0 mid-cycle during ACCUM -> all outputs 0 immediately. After release, 9x P=7 -> acc_out=63.
- ACC_SIGNED_EN defined: P=12'hFFF x9 -> acc_out=20'hFFFF7 (-9), overflow=0.

Source files
------------

// File: rtl/pe_product_accumulator.sv
// Windowed accumulator for the mult_ip product stream: sums LEN products and hands each sum out on valid/ready.
// Build option ACC_SIGNED_EN: treat products as two's complement and flag signed overflow.
module pe_product_accumulator #(
    parameter int P_W   = 12,
    parameter int ACC_W = 20,
    parameter int LEN   = 9,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   P,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;

    logic             in_window;
    logic             accept;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] add_base;
    logic [ACC_W-1:0] sum;
    logic             step_ovf;
    logic [CNT_W-1:0] cnt_inc;

    // Outside ACCUM the next accept starts a fresh window, so it adds onto zero.
    assign in_window = (state_q == ACCUM);
    assign add_base  = in_window ? acc_q : '0;
    assign cnt_inc   = (in_window ? cnt_q : '0) + CNT_W'(1);

`ifdef ACC_SIGNED_EN
    assign p_ext    = ACC_W'(signed'(P));
    assign sum      = add_base + p_ext;
    assign step_ovf = (add_base[ACC_W-1] == p_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != add_base[ACC_W-1]);
`else
    assign p_ext = ACC_W'(P);
    assign {step_ovf, sum} = {1'b0, add_base} + {1'b0, p_ext};
`endif

    assign in_ready = en & ((state_q != HOLD) | out_ready);
    assign accept   = en & in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_out_d   = acc_out_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else if (en) begin
            if ((state_q == HOLD) && out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            if (accept) begin
                overflow_d = (in_window & overflow_q) | step_ovf;
                if (cnt_inc == CNT_W'(LEN)) begin
                    acc_out_d   = sum;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d   = sum;
                    cnt_d   = cnt_inc;
                    state_d = ACCUM;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_out_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_out_q   <= acc_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE);

endmodule
